// File: rtl/keypad_multi_digit_display.sv
// rtl/keypad_multi_digit_display.sv - N-digit keypad entry buffer with multiplexed seven-segment scan
// Optional feature: define KMDD_LEADING_BLANK_EN to blank display positions not yet entered.
module keypad_multi_digit_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 2000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [3:0]                        key_digit,
  input  logic                              clear,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int EW = $clog2(NUM_DIGITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LIM  = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [EW-1:0] COUNT_MAX = EW'(NUM_DIGITS);

  logic [3:0]    r_digit [NUM_DIGITS];
  logic [EW-1:0] r_count;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]    r_seg;

  logic          w_dead;
  logic          w_blank;
  logic [3:0]    w_cur_digit;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    case (d)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Slot timer and scan index; the index steps once per full slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Digit buffer: new keys enter on the right, clear wins over a same-cycle key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= 4'h0;
      r_count <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= 4'h0;
      r_count <= '0;
    end else if (key_valid) begin
      for (int k = NUM_DIGITS - 1; k > 0; k--) r_digit[k] <= r_digit[k-1];
      r_digit[0] <= key_digit;
      r_count    <= (r_count == COUNT_MAX) ? r_count : r_count + 1'b1;
    end
  end

  // Dead window at the start of each slot keeps all enables off to suppress ghosting.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < DEAD_LIM);
    end
  endgenerate

  // Select the digit at the current scan position without a variable-width array index.
  always_comb begin
    w_cur_digit = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) w_cur_digit = r_digit[k];
    end
  end

`ifdef KMDD_LEADING_BLANK_EN
  assign w_blank = (EW'(r_idx) >= r_count);
`else
  assign w_blank = 1'b0;
`endif

  // Registered pin drive: enables and segments always change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else if (w_dead) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_blank ? 7'h7F : hex_decode(w_cur_digit);
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign entry_count = r_count;

endmodule

// File: tb/tb_keypad_multi_digit_display.sv
// tb/tb_keypad_multi_digit_display.sv - scoreboard bench for keypad_multi_digit_display
module tb_keypad_multi_digit_display;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'h0;
  logic       clear = 1'b0;
  logic [6:0] seg, seg1;
  logic [3:0] an;
  logic       an1;
  logic [2:0] ec;
  logic       ec1;

  keypad_multi_digit_display #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit), .clear(clear),
    .seg(seg), .an(an), .entry_count(ec));

  keypad_multi_digit_display #(.NUM_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit), .clear(clear),
    .seg(seg1), .an(an1), .entry_count(ec1));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] ec;
    logic       an1;
    logic [6:0] seg1;
    logic       ec1;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int vectors = 0;
  int errors = 0;
  logic [6:0] exp_seg [N];
  int t = 0;
  int cnt_now = 0;

  function automatic logic [6:0] segpat(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'hA: return 7'b0001000;
      4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per clock edge that had one queued.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("an", 32'(an), 32'(m.an));
      chk("seg", 32'(seg), 32'(m.seg));
      chk("entry_count", 32'(ec), 32'(m.ec));
      chk("an_n1", 32'(an1), 32'(m.an1));
      chk("seg_n1", 32'(seg1), 32'(m.seg1));
      chk("entry_count_n1", 32'(ec1), 32'(m.ec1));
    end
  end

  task automatic cyc(input logic rstn, input logic kv, input logic [3:0] kd,
                     input logic clr, input int cnt_after);
    exp_t e;
    int ph, slot;
    @(negedge clk);
    reset = rstn; key_valid = kv; key_digit = kd; clear = clr;
    if (!rstn) begin
      t = 0;
      cnt_now = 0;
      for (int k = 0; k < N; k++) exp_seg[k] = segpat(4'h0);
      e = '{4'hF, 7'h7F, 3'd0, 1'b1, 7'h7F, 1'b0};
    end else begin
      t++;
      ph   = (t - 1) % RD;
      slot = ((t - 1) / RD) % N;
      if (ph < DC) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end else begin
        e.an  = ~(4'b0001 << slot);
        e.seg = exp_seg[slot];
`ifdef KMDD_LEADING_BLANK_EN
        if (slot >= cnt_now) e.seg = 7'h7F;
`endif
      end
      e.an1  = 1'b0;
      e.seg1 = exp_seg[0];
`ifdef KMDD_LEADING_BLANK_EN
      if (cnt_now == 0) e.seg1 = 7'h7F;
`endif
      e.ec  = 3'(cnt_after);
      e.ec1 = (cnt_after > 0);
      cnt_now = cnt_after;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 4'h0, 1'b0, cnt_now);
  endtask

  task automatic key(input logic [3:0] d, input int cnt_after);
    cyc(1'b1, 1'b1, d, 1'b0, cnt_after);
    for (int k = N - 1; k > 0; k--) exp_seg[k] = exp_seg[k-1];
    exp_seg[0] = segpat(d);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < N; k++) exp_seg[k] = 7'b1000000;

    // Reset held, then a full scan frame of an idle, all-zero buffer.
    repeat (3) cyc(1'b0, 1'b0, 4'h0, 1'b0, 0);
    idle(34);

    // Keys 1..5: oldest digit falls off, count saturates at 4.
    for (int i = 1; i <= 5; i++) begin
      key(4'(i), (i > 4) ? 4 : i);
      idle(3);
    end
    idle(34);

    // Clear together with a key: the key is dropped.
    cyc(1'b1, 1'b1, 4'hA, 1'b1, 0);
    for (int k = 0; k < N; k++) exp_seg[k] = 7'b1000000;
    idle(34);

    // One key F into an empty buffer.
    key(4'hF, 1);
    idle(34);

    // Run to slot 2 active phase, then drop reset between clock edges.
    guard = 0;
    while (!((((t - 1) / RD) % N == 2) && ((t - 1) % RD == 3)) && guard < 64) begin
      idle(1);
      guard++;
    end
    chk("reach_slot2", 32'(guard < 64), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_count", 32'(ec), 32'd0);
    chk("async_an_n1", 32'(an1), 32'd1);
    repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0, 0);
    idle(20);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_multi_digit_display.md
Name: keypad_multi_digit_display

Overview:
Parametrised N-digit entry buffer and time-multiplexed seven-segment driver for keypad input. Each validated key pulse shifts a new hex digit in on the right. The block scans all NUM_DIGITS displays with a configurable slot length and inter-digit dead time (ghost suppression). It sits between the keypad FSM (key_valid/key_digit) and the board's segment/enable pins, and replaces the fixed two-digit shift-plus-mux arrangement.

Parameters:
NUM_DIGITS, 4, number of displays and buffered digits (1..8)
REFRESH_DIV, 24000, clk cycles per digit slot (>= 2)
DEAD_CYCLES, 2000, cycles at slot start with all enables off (0 <= DEAD_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock (HSOSC-derived)
reset  input  1  asynchronous, active-low reset
key_valid  input  1  single-cycle pulse: key_digit is a new entry
key_digit  input  4  hex value of the entry
clear  input  1  synchronous single-cycle pulse: empty the buffer
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low
an  output  NUM_DIGITS  display enables, active-low; bit 0 = rightmost (newest)
entry_count  output  $clog2(NUM_DIGITS+1)  digits entered since reset/clear, saturating at NUM_DIGITS

Behaviour:
- Reset (reset==0, asynchronous assert, synchronous release):
  - all digits 4'h0; entry_count 0; refresh counter 0; scan index 0.
  - an all 1s; seg 7'h7F.
- Digit buffer: digit[0..NUM_DIGITS-1], digit[0] rightmost.
  - On key_valid: digit[k] <= digit[k-1] for k>=1; digit[0] <= key_digit; entry_count <= min(entry_count+1, NUM_DIGITS).
  - The oldest digit falls off the left end.
- clear has priority over a simultaneous key_valid: all digits 0, entry_count 0, and the key is dropped. clear does not disturb the scan counters.
- Refresh counter:
  - Width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, scan index advances idx -> (idx+1) mod NUM_DIGITS; NUM_DIGITS-1 wraps to 0.
  - NUM_DIGITS==1: index is constantly 0.
- Output stage is registered; an and seg always update on the same edge.
  - If refresh count < DEAD_CYCLES: an = all 1s, seg = 7'h7F.
  - Otherwise: an = ~(1 << idx), seg = hex_decode(digit[idx]).
  - Latency: the registered outputs reflect the counter/index/buffer state of the previous cycle. A key accepted at edge N is visible on seg at edge N+1 if its digit is being scanned.
- hex_decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Exactly zero or one bit of an is low in every cycle.
- Reset mid-slot: all outputs return to reset values immediately, and scanning restarts from slot 0.

Optional Feature:
Macro KMDD_LEADING_BLANK_EN.
- Defined: a display whose position idx >= entry_count shows blank (seg 7'h7F). Its an bit is still driven per scan, so timing is unchanged. After reset or clear, all displays are blank until entries arrive.
- Undefined: unentered positions show 0 (decode of 4'h0).

Test Plan:
1. Reset/scan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2): hold reset=0, then release.
   - While reset=0: an=4'b1111, seg=7'h7F.
   - After release: each 8-cycle slot has 2 cycles an=1111, then 6 cycles an=1110, 1101, 1011, 0111 in turn, repeating.
2. Entry shift: keys 1,2,3,4,5.
   - Slot scans show digit[3..0]=2,3,4,5.
   - Slot 0 seg=0010010; entry_count saturates at 4.
3. clear with key_valid in the same cycle, key=4'hA: buffer all 0, entry_count=0, A not stored.
   - Without the macro: seg=1000000 in every active slot.
4. Mid-slot async reset during slot 2, active phase: an goes to 1111 and seg to 7'h7F within the same cycle, without waiting for a clock edge. After release, scanning resumes from slot 0.
5. KMDD_LEADING_BLANK_EN defined, one key 4'hF: slot 0 seg=0001110, slots 1-3 seg=7'h7F, an bits still toggle.
6. Parameter corners:
   - NUM_DIGITS=1: an=0/1 per dead window.
   - DEAD_CYCLES=0: no blank cycles; every cycle has exactly one an bit low.
